// File: rtl/adc_pkg.sv
// Shared types and constants for the serial ADC reader.
package adc_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int MIN_CLK_DIV = 4;
    localparam int AVG_DEPTH   = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        NULLBIT,
        SHIFT,
        DONE
    } adcState_e;

endpackage

// File: rtl/adc_spi_reader_sclk_gen.sv
// Serial clock generator: toggles sclk every CLK_DIV enabled cycles and
// flags the cycle before each edge so the caller can act on that edge.
module adc_sclk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic          sclk_q;
    logic          lastCycle;

    assign lastCycle = (cnt_q == CW'(CLK_DIV - 1));

    // Dropping enable parks sclk low with a fresh half-period ahead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (lastCycle) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sclk_o = sclk_q;
    assign rise_o = en_i & lastCycle & ~sclk_q;
    assign fall_o = en_i & lastCycle & sclk_q;

endmodule

// File: rtl/adc_spi_reader.sv
// ADC0831-style serial reader: null bit then MSB-first data, parallel result out.
// Define ADC_AVG4_EN to present the mean of the last four conversions instead.
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV   = 8,
    parameter int CONV_WAIT = 4,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              adc_miso,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy
);

    localparam int WW = $clog2(CONV_WAIT + 1);
    localparam int BW = $clog2(DATA_W + 1);

    if (CLK_DIV < MIN_CLK_DIV) begin : gClkDivCheck
        $error("adc_spi_reader: CLK_DIV must be at least %0d", MIN_CLK_DIV);
    end

    adcState_e         state_q;
    logic              misoMeta_q;
    logic              misoSync_q;
    logic              reqPrev_q;
    logic [WW-1:0]     waitCnt_q;
    logic [BW-1:0]     bitCnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] sample_q;
    logic              csN_q;
    logic              busy_q;
    logic              valid_q;
    logic [DATA_W-1:0] result;
    logic              sclkEn;
    logic              sclkRise;
    logic              sclkFall;

    assign sclkEn = (state_q == NULLBIT) || (state_q == SHIFT);

    adc_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) uSclkGen (
        .clk   (clk),
        .reset (reset),
        .en_i  (sclkEn),
        .sclk_o(adc_sclk),
        .rise_o(sclkRise),
        .fall_o(sclkFall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misoMeta_q <= 1'b0;
            misoSync_q <= 1'b0;
        end else begin
            misoMeta_q <= adc_miso;
            misoSync_q <= misoMeta_q;
        end
    end

    // reqPrev_q resets high so a request already asserted at reset release
    // has to drop and rise again before it starts a conversion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            reqPrev_q <= 1'b1;
            waitCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            sample_q  <= '0;
            csN_q     <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            reqPrev_q <= req;
            valid_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req && !reqPrev_q) begin
                        state_q   <= SETUP;
                        csN_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        waitCnt_q <= '0;
                    end
                end
                SETUP: begin
                    if (waitCnt_q == WW'(CONV_WAIT - 1)) begin
                        state_q <= NULLBIT;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                NULLBIT: begin
                    if (sclkFall) begin
                        state_q  <= SHIFT;
                        bitCnt_q <= '0;
                    end
                end
                SHIFT: begin
                    // bitCnt_q counts sclk periods begun; the last one ends the transfer.
                    if (sclkRise) begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                    if (sclkFall) begin
                        shift_q <= {shift_q[DATA_W-2:0], misoSync_q};
                        if (bitCnt_q == BW'(DATA_W)) begin
                            state_q <= DONE;
                            csN_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    sample_q <= result;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ADC_AVG4_EN
    logic [DATA_W-1:0] hist_q [AVG_DEPTH-1];
    logic [DATA_W+1:0] sum_d;

    always_comb begin
        sum_d = {2'b00, shift_q};
        for (int i = 0; i < AVG_DEPTH - 1; i++) begin
            sum_d = sum_d + {2'b00, hist_q[i]};
        end
    end

    assign result = DATA_W'(sum_d >> $clog2(AVG_DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < AVG_DEPTH - 1; i++) begin
                hist_q[i] <= '0;
            end
        end else if (state_q == DONE) begin
            hist_q[0] <= shift_q;
            for (int i = 1; i < AVG_DEPTH - 1; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end
`else
    assign result = shift_q;
`endif

    assign adc_cs_n     = csN_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: two instances (CLK_DIV 8 and 4) each fed by a
// jittery ADC model; table-driven conversions plus retrigger and reset cases.
module tb_adc_spi_reader;

    typedef struct packed {
        logic       nul;
        logic [7:0] word;
        logic [7:0] expSample;
    } vecT;

    logic       clk = 1'b0;
    logic       reset;
    logic       req      [2];
    logic       miso     [2];
    logic       csN      [2];
    logic       sclk     [2];
    logic [7:0] sample   [2];
    logic       valid    [2];
    logic       busy     [2];
    logic [7:0] adcWord  [2];
    logic       adcNull  [2];

    int total;
    int bad;

`ifdef ADC_AVG4_EN
    logic [7:0] hist [2][3];
`endif

    always #5 clk = ~clk;

    adc_spi_reader #(.CLK_DIV(8), .CONV_WAIT(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .req(req[0]), .adc_miso(miso[0]),
        .adc_cs_n(csN[0]), .adc_sclk(sclk[0]), .sample(sample[0]),
        .sample_valid(valid[0]), .busy(busy[0])
    );

    adc_spi_reader #(.CLK_DIV(4), .CONV_WAIT(4), .DATA_W(8)) dut4 (
        .clk(clk), .reset(reset), .req(req[1]), .adc_miso(miso[1]),
        .adc_cs_n(csN[1]), .adc_sclk(sclk[1]), .sample(sample[1]),
        .sample_valid(valid[1]), .busy(busy[1])
    );

    // ADC model: null bit from chip-select fall, next bit on each sclk rise,
    // random garbage after each sclk fall; every change lands at a random
    // offset inside the clock period.
    task automatic adcModel(input int g);
        int   rises = 0;
        logic pCs   = 1'b1;
        logic pSclk = 1'b0;
        logic cs;
        logic sc;
        miso[g] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cs = csN[g];
            sc = sclk[g];
            if (pCs && !cs) begin
                rises = 0;
                pCs = cs;
                pSclk = sc;
                #($urandom_range(1, 8));
                miso[g] = adcNull[g];
            end else if (!cs && sc && !pSclk) begin
                rises++;
                pCs = cs;
                pSclk = sc;
                #($urandom_range(1, 8));
                if (rises <= 1) miso[g] = adcNull[g];
                else if (rises <= 9) miso[g] = adcWord[g][9-rises];
            end else if (!cs && !sc && pSclk) begin
                pCs = cs;
                pSclk = sc;
                #($urandom_range(1, 8));
                miso[g] = 1'($urandom);
            end else begin
                pCs = cs;
                pSclk = sc;
            end
        end
    endtask

    initial begin
        fork
            adcModel(0);
            adcModel(1);
        join_none
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int g);
        @(negedge clk);
        req[g] = 1'b1;
    endtask

    function automatic logic [7:0] expectedFor(input int g, input logic [7:0] raw,
                                               input logic [7:0] tableExp);
`ifdef ADC_AVG4_EN
        logic [9:0] sum;
        sum = {2'b00, raw} + {2'b00, hist[g][0]} + {2'b00, hist[g][1]} + {2'b00, hist[g][2]};
        hist[g][2] = hist[g][1];
        hist[g][1] = hist[g][0];
        hist[g][0] = raw;
        return sum[9:2];
`else
        return (g < 0) ? raw : tableExp;
`endif
    endfunction

    task automatic clearModel();
`ifdef ADC_AVG4_EN
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 3; i++) hist[g][i] = 8'h00;
`endif
    endtask

    // mode 0: req dropped after 5 cycles; mode 1: also re-raised at cycle 40 and held.
    task automatic doConversion(input int g, input logic nul, input logic [7:0] word,
                                input logic [7:0] expS, input int expLat, input int mode,
                                input string name);
        int         rises = 0;
        int         validAt = 0;
        int         validCnt = 0;
        int         csBad = 0;
        int         stableBad = 0;
        logic       busyAt1 = 1'b0;
        logic       prevS = 1'b0;
        logic [7:0] startSample;
        adcNull[g] = nul;
        adcWord[g] = word;
        startSample = sample[g];
        applyStimulus(g);
        for (int k = 1; k <= expLat + 20; k++) begin
            @(negedge clk);
            if (k == 1) busyAt1 = busy[g];
            if (sclk[g] && !prevS) rises++;
            prevS = sclk[g];
            if (valid[g]) begin
                validCnt++;
                if (validAt == 0) validAt = k;
            end
            if (validAt == 0 && !valid[g] && sample[g] !== startSample) stableBad = 1;
            if (k <= expLat - 2 && csN[g] !== 1'b0) csBad = 1;
            if (k == 5) req[g] = 1'b0;
            if (mode == 1 && k == 40) req[g] = 1'b1;
        end
        checkOutput({name, "_busyStart"}, busyAt1, 1);
        checkOutput({name, "_latency"}, validAt, expLat);
        checkOutput({name, "_validPulses"}, validCnt, 1);
        checkOutput({name, "_sclkRises"}, rises, 9);
        checkOutput({name, "_csLowGaps"}, csBad, 0);
        checkOutput({name, "_sampleMoved"}, stableBad, 0);
        checkOutput({name, "_sample"}, sample[g], expS);
        checkOutput({name, "_busyEnd"}, busy[g], 0);
        checkOutput({name, "_csEnd"}, csN[g], 1);
        checkOutput({name, "_sclkEnd"}, sclk[g], 0);
    endtask

    task automatic checkIdle(input int g, input int cycles, input string name);
        int idleBad = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (busy[g] !== 1'b0 || csN[g] !== 1'b1 || valid[g] !== 1'b0) idleBad++;
        end
        checkOutput(name, idleBad, 0);
    endtask

    initial begin
        vecT        tab [4];
        vecT        avgTab [5];
        logic [7:0] w;
        logic       n;
        total = 0;
        bad = 0;
        reset = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        adcWord[0] = 8'h00;
        adcWord[1] = 8'h00;
        adcNull[0] = 1'b0;
        adcNull[1] = 1'b0;
        clearModel();

        tab[0] = '{nul: 1'b0, word: 8'hA5, expSample: 8'hA5};
        tab[1] = '{nul: 1'b1, word: 8'h00, expSample: 8'h00};
        tab[2] = '{nul: 1'b0, word: 8'hFF, expSample: 8'hFF};
        tab[3] = '{nul: 1'b1, word: 8'h69, expSample: 8'h69};
        avgTab[0] = '{nul: 1'b0, word: 8'h10, expSample: 8'h04};
        avgTab[1] = '{nul: 1'b1, word: 8'h20, expSample: 8'h0C};
        avgTab[2] = '{nul: 1'b0, word: 8'h30, expSample: 8'h18};
        avgTab[3] = '{nul: 1'b1, word: 8'h40, expSample: 8'h28};
        avgTab[4] = '{nul: 1'b0, word: 8'h50, expSample: 8'h38};

        repeat (3) @(negedge clk);
        checkOutput("rst_csN", csN[0], 1);
        checkOutput("rst_sclk", sclk[0], 0);
        checkOutput("rst_sample", sample[0], 0);
        checkOutput("rst_valid", valid[0], 0);
        checkOutput("rst_busy", busy[0], 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            doConversion(0, tab[i].nul, tab[i].word,
                         expectedFor(0, tab[i].word, tab[i].expSample), 150, 0,
                         $sformatf("vec%0d", i));
        end

        $display("[TB] retrigger during conversion and req held high after done");
        doConversion(0, 1'b0, 8'h5A, expectedFor(0, 8'h5A, 8'h5A), 150, 1, "retrig");
        checkIdle(0, 200, "heldHighNoRetrig");
        req[0] = 1'b0;
        @(negedge clk);
        doConversion(0, 1'b0, 8'h3C, expectedFor(0, 8'h3C, 8'h3C), 150, 0, "newEdge");

        $display("[TB] reset in mid conversion");
        adcWord[0] = 8'hC3;
        applyStimulus(0);
        repeat (70) @(negedge clk);
        checkOutput("midConv_csLow", csN[0], 0);
        reset = 1'b0;
        #1;
        checkOutput("midRst_csN", csN[0], 1);
        checkOutput("midRst_sclk", sclk[0], 0);
        checkOutput("midRst_sample", sample[0], 0);
        checkOutput("midRst_busy", busy[0], 0);
        clearModel();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        checkIdle(0, 40, "reqHighAtReleaseNoStart");
        req[0] = 1'b0;
        @(negedge clk);
        doConversion(0, 1'b1, 8'h96, expectedFor(0, 8'h96, 8'h96), 150, 0, "afterRst");

        $display("[TB] CLK_DIV=4 instance with random data");
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            n = 1'($urandom);
            doConversion(1, n, w, expectedFor(1, w, w), 78, 0, $sformatf("div4_%0d", i));
        end

`ifdef ADC_AVG4_EN
        $display("[TB] four-deep averaging");
        @(negedge clk);
        reset = 1'b0;
        clearModel();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            doConversion(0, avgTab[i].nul, avgTab[i].word, avgTab[i].expSample, 150, 0,
                         $sformatf("avg%0d", i));
        end
`else
        if (avgTab[0].word != 8'h10) $display("[TB] averaging table unused in this build");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
